// File: rtl/banked_program_memory.sv
// Writable banked instruction store: NUM_PROGRAMS banks of 2^ADDR_WIDTH words, one-cycle fetch,
// valid/ready program loads, HALT fill on reset and per-bank clear (fetch > clear > load).
module banked_program_memory #(
  parameter int                     INSTR_WIDTH  = 16,
  parameter int                     ADDR_WIDTH   = 8,
  parameter int                     NUM_PROGRAMS = 4,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD    = 16'hE000,
  localparam int                    SEL_WIDTH    = $clog2(NUM_PROGRAMS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEL_WIDTH-1:0]   programSelect,
  input  logic                   fetchReq,
  input  logic [ADDR_WIDTH-1:0]  fetchAddr,
  output logic                   fetchReady,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instructionValid,
  input  logic                   loadValid,
  input  logic [SEL_WIDTH-1:0]   loadProgram,
  input  logic [ADDR_WIDTH-1:0]  loadAddr,
  input  logic [INSTR_WIDTH-1:0] loadData,
  output logic                   loadReady,
  input  logic                   clearReq,
  input  logic [SEL_WIDTH-1:0]   clearProgram,
  output logic                   busy
);

  localparam int MEM_AW = SEL_WIDTH + ADDR_WIDTH;
  localparam int DEPTH  = 2 ** MEM_AW;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam logic [MEM_AW-1:0] SWEEP_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  logic [1:0]             r_state;
  logic [MEM_AW-1:0]      r_sweep;
  logic [SEL_WIDTH-1:0]   r_clr_bank;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_ivalid;
  logic [INSTR_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                   w_idle;
  logic                   w_fetch_acc;
  logic                   w_clear_acc;
  logic                   w_load_acc;
  logic                   w_init_last;
  logic                   w_clear_last;
  logic                   w_we;
  logic [MEM_AW-1:0]      w_waddr;
  logic [INSTR_WIDTH-1:0] w_wdata;
  logic [MEM_AW-1:0]      w_raddr;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_fetch_acc  = w_idle && fetchReq;
  assign w_clear_acc  = w_idle && clearReq && !fetchReq;
  assign w_load_acc   = loadValid && loadReady;
  assign w_init_last  = (r_sweep == {MEM_AW{1'b1}});
  assign w_clear_last = (r_sweep[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});

  assign fetchReady       = w_idle;
  assign loadReady        = w_idle && !fetchReq && !clearReq;
  assign busy             = !w_idle;
  assign instruction      = r_instr;
  assign instructionValid = r_ivalid;

  assign w_raddr = {programSelect, fetchAddr};

  // The single array port is shared: sweeps own it while busy, otherwise a load may write it.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = {loadProgram, loadAddr};
    w_wdata = loadData;
    case (r_state)
      ST_INIT: begin
        w_we    = 1'b1;
        w_waddr = r_sweep;
        w_wdata = HALT_WORD;
      end
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = {r_clr_bank, r_sweep[ADDR_WIDTH-1:0]};
        w_wdata = HALT_WORD;
      end
      default: begin
        w_we = w_load_acc;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Counter holds at its terminal value when a sweep ends; a clear reloads it from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_sweep    <= '0;
      r_clr_bank <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (w_init_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_sweep <= r_sweep + SWEEP_ONE;
          end
        end
        ST_CLEAR: begin
          if (w_clear_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_sweep <= r_sweep + SWEEP_ONE;
          end
        end
        ST_IDLE: begin
          if (w_clear_acc) begin
            r_state    <= ST_CLEAR;
            r_sweep    <= '0;
            r_clr_bank <= clearProgram;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_sweep <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr  <= '0;
      r_ivalid <= 1'b0;
    end else begin
      r_ivalid <= w_fetch_acc;
      if (w_fetch_acc) begin
        r_instr <= r_mem[w_raddr];
      end
    end
  end

endmodule

// File: tb/tb_banked_program_memory.sv
// Directed bench for banked_program_memory: init sweep, loads, fetch/load/clear arbitration,
// bank clear and reset during clear/fetch.
module tb_banked_program_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  programSelect;
  logic        fetchReq;
  logic [7:0]  fetchAddr;
  logic        fetchReady;
  logic [15:0] instruction;
  logic        instructionValid;
  logic        loadValid;
  logic [1:0]  loadProgram;
  logic [7:0]  loadAddr;
  logic [15:0] loadData;
  logic        loadReady;
  logic        clearReq;
  logic [1:0]  clearProgram;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  addr;
    logic [15:0] data;
  } vec_t;

  vec_t prog4 [10];
  vec_t after_clear [6];
  vec_t after_reset [6];

  banked_program_memory dut (
    .clk(clk), .reset(reset),
    .programSelect(programSelect), .fetchReq(fetchReq), .fetchAddr(fetchAddr),
    .fetchReady(fetchReady), .instruction(instruction), .instructionValid(instructionValid),
    .loadValid(loadValid), .loadProgram(loadProgram), .loadAddr(loadAddr),
    .loadData(loadData), .loadReady(loadReady),
    .clearReq(clearReq), .clearProgram(clearProgram), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts busy cycles (bounded) and confirms the ports stay closed meanwhile.
  task automatic wait_idle(input string name, input int exp_cycles);
    int cnt = 0;
    logic leak = 1'b0;
    while (busy && cnt < 3000) begin
      @(posedge clk); #1;
      cnt++;
      if (busy && (fetchReady || loadReady || instructionValid)) leak = 1'b1;
    end
    fetchReq  = 1'b0;
    loadValid = 1'b0;
    clearReq  = 1'b0;
    check({name, "_cycles"}, cnt, exp_cycles);
    check({name, "_ports_closed"}, {31'd0, leak}, 32'd0);
  endtask

  task automatic fetch(input string name, input logic [1:0] sel, input logic [7:0] addr,
                       input logic [15:0] exp);
    programSelect = sel;
    fetchAddr     = addr;
    fetchReq      = 1'b1;
    #1;
    check({name, "_ready"}, {31'd0, fetchReady}, 32'd1);
    @(posedge clk); #1;
    fetchReq = 1'b0;
    check({name, "_valid"}, {31'd0, instructionValid}, 32'd1);
    check({name, "_data"}, {16'd0, instruction}, {16'd0, exp});
  endtask

  task automatic load(input logic [1:0] sel, input logic [7:0] addr, input logic [15:0] data);
    loadProgram = sel;
    loadAddr    = addr;
    loadData    = data;
    loadValid   = 1'b1;
    @(posedge clk); #1;
    loadValid = 1'b0;
  endtask

  initial begin
    prog4[0] = '{2'd1, 8'd0, 16'h1101};
    prog4[1] = '{2'd1, 8'd1, 16'h1202};
    prog4[2] = '{2'd1, 8'd2, 16'h2310};
    prog4[3] = '{2'd1, 8'd3, 16'h3421};
    prog4[4] = '{2'd1, 8'd4, 16'h4530};
    prog4[5] = '{2'd1, 8'd5, 16'h5641};
    prog4[6] = '{2'd1, 8'd6, 16'h6750};
    prog4[7] = '{2'd1, 8'd7, 16'h7861};
    prog4[8] = '{2'd1, 8'd8, 16'h8970};
    prog4[9] = '{2'd1, 8'd9, 16'hE000};

    after_clear[0] = '{2'd1, 8'd0,   16'hE000};
    after_clear[1] = '{2'd1, 8'd5,   16'hE000};
    after_clear[2] = '{2'd1, 8'd255, 16'hE000};
    after_clear[3] = '{2'd0, 8'd7,   16'h0A0A};
    after_clear[4] = '{2'd3, 8'd0,   16'h0105};
    after_clear[5] = '{2'd2, 8'd1,   16'h4F21};

    after_reset[0] = '{2'd0, 8'd7,   16'hE000};
    after_reset[1] = '{2'd1, 8'd3,   16'hE000};
    after_reset[2] = '{2'd2, 8'd1,   16'hE000};
    after_reset[3] = '{2'd3, 8'd0,   16'hE000};
    after_reset[4] = '{2'd3, 8'd255, 16'hE000};
    after_reset[5] = '{2'd0, 8'd0,   16'hE000};

    reset = 1'b1;
    programSelect = '0; fetchReq = 1'b0; fetchAddr = '0;
    loadValid = 1'b0; loadProgram = '0; loadAddr = '0; loadData = '0;
    clearReq = 1'b0; clearProgram = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_fetchReady", {31'd0, fetchReady}, 32'd0);
    check("rst_loadReady", {31'd0, loadReady}, 32'd0);
    check("rst_valid", {31'd0, instructionValid}, 32'd0);
    check("rst_instr", {16'd0, instruction}, 32'd0);
    reset = 1'b0;
    wait_idle("init", 1024);

    fetch("halt_b2a5", 2'd2, 8'd5, 16'hE000);
    @(posedge clk); #1;
    check("valid_pulse_falls", {31'd0, instructionValid}, 32'd0);
    check("instr_holds", {16'd0, instruction}, 32'h0000E000);

    load(2'd3, 8'd0, 16'h0105);
    fetch("load_b3a0", 2'd3, 8'd0, 16'h0105);
    fetch("untouched_b0a0", 2'd0, 8'd0, 16'hE000);

    // Fetch and load contend for the port: fetch wins, the load is held and lands a cycle later.
    load(2'd2, 8'd1, 16'h2F10);
    loadProgram = 2'd2; loadAddr = 8'd1; loadData = 16'h4F21; loadValid = 1'b1;
    programSelect = 2'd2; fetchAddr = 8'd1; fetchReq = 1'b1;
    #1;
    check("contend_loadReady", {31'd0, loadReady}, 32'd0);
    @(posedge clk); #1;
    fetchReq = 1'b0;
    check("contend_fetch_old", {16'd0, instruction}, 32'h00002F10);
    check("contend_valid", {31'd0, instructionValid}, 32'd1);
    #1;
    check("held_loadReady", {31'd0, loadReady}, 32'd1);
    @(posedge clk); #1;
    loadValid = 1'b0;
    fetch("contend_fetch_new", 2'd2, 8'd1, 16'h4F21);

    for (int i = 0; i < 10; i++) load(prog4[i].sel, prog4[i].addr, prog4[i].data);
    fetchReq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      programSelect = prog4[i].sel;
      fetchAddr     = prog4[i].addr;
      @(posedge clk); #1;
      check($sformatf("burst_valid_%0d", i), {31'd0, instructionValid}, 32'd1);
      check($sformatf("burst_data_%0d", i), {16'd0, instruction}, {16'd0, prog4[i].data});
    end
    fetchReq = 1'b0;
    @(posedge clk); #1;
    check("burst_valid_end", {31'd0, instructionValid}, 32'd0);

    // Clear competes with a fetch first, so it only starts once the fetch goes away.
    load(2'd0, 8'd7, 16'h0A0A);
    clearProgram = 2'd1; clearReq = 1'b1;
    programSelect = 2'd0; fetchAddr = 8'd7; fetchReq = 1'b1;
    #1;
    check("clr_fetch_loadReady", {31'd0, loadReady}, 32'd0);
    @(posedge clk); #1;
    fetchReq = 1'b0;
    check("clr_blocked_busy", {31'd0, busy}, 32'd0);
    check("clr_blocked_fetch", {16'd0, instruction}, 32'h00000A0A);
    #1;
    check("clr_only_loadReady", {31'd0, loadReady}, 32'd0);
    @(posedge clk); #1;
    clearReq = 1'b0;
    check("clr_started", {31'd0, busy}, 32'd1);
    loadProgram = 2'd0; loadAddr = 8'd7; loadData = 16'hBAD0; loadValid = 1'b1;
    programSelect = 2'd0; fetchAddr = 8'd7; fetchReq = 1'b1;
    clearProgram = 2'd0; clearReq = 1'b1;
    wait_idle("clear", 256);
    check("clr_instr_kept", {16'd0, instruction}, 32'h00000A0A);
    for (int i = 0; i < 6; i++)
      fetch($sformatf("post_clear_%0d", i), after_clear[i].sel, after_clear[i].addr,
            after_clear[i].data);

    programSelect = 2'd3; fetchAddr = 8'd0; fetchReq = 1'b1;
    @(posedge clk); #1;
    check("midfetch_valid", {31'd0, instructionValid}, 32'd1);
    reset = 1'b1;
    #1;
    fetchReq = 1'b0;
    check("midfetch_rst_valid", {31'd0, instructionValid}, 32'd0);
    check("midfetch_rst_busy", {31'd0, busy}, 32'd1);
    check("midfetch_rst_instr", {16'd0, instruction}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_idle("reinit1", 1024);

    clearProgram = 2'd3; clearReq = 1'b1;
    @(posedge clk); #1;
    clearReq = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("midclear_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midclear_rst_busy", {31'd0, busy}, 32'd1);
    check("midclear_rst_valid", {31'd0, instructionValid}, 32'd0);
    @(posedge clk); #1;
    check("midclear_rst_hold", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    wait_idle("reinit2", 1024);
    for (int i = 0; i < 6; i++)
      fetch($sformatf("post_reset_%0d", i), after_reset[i].sel, after_reset[i].addr,
            after_reset[i].data);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
